// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer controller.
//   STATE_W : width of the controller state register / debug LED bus
//   state_e : controller states, encoded as the debug LEDs show them
package timer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

endpackage

// File: rtl/timer_controller_if.sv
// Signal bundle between the timer controller and its counter/display datapath.
//   slave  : controller side (takes tick, buttons, preset, all_zero;
//            drives count_load, count_enable, alarm, display_blank, state)
//   master : datapath / environment side (mirror image)
interface timer_controller_if #(
  parameter int MIN_W = 2
);
  import timer_pkg::*;

  logic                tick_1hz;
  logic                start_stop;
  logic                clear;
  logic [MIN_W-1:0]    start_minutes;
  logic                all_zero;
  logic                count_load;
  logic                count_enable;
  logic                alarm;
  logic                display_blank;
  logic [STATE_W-1:0]  state;

  modport slave (
    input  tick_1hz, start_stop, clear, start_minutes, all_zero,
    output count_load, count_enable, alarm, display_blank, state
  );

  modport master (
    output tick_1hz, start_stop, clear, start_minutes, all_zero,
    input  count_load, count_enable, alarm, display_blank, state
  );

endinterface

// File: rtl/timer_controller_button_edge.sv
// Button conditioner: two-flop synchronizer followed by a rising-edge detector.
// A held level produces exactly one press pulse, one clk wide.
//   clk   : system clock
//   reset : synchronous active-high reset
//   raw   : asynchronous button level
//   press : one-clk pulse on a synchronized rising edge
module button_edge (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  logic       sync1_r;
  logic       sync2_r;
  logic       prev_r;
  // Fills with ones after reset; prev_r only holds a real button sample once
  // the top bit is set, so a button held through reset never looks like a rise.
  logic [2:0] fill_r;

  // Synchronizer, edge-detect history and post-reset fill tracker.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      fill_r  <= 3'b000;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      fill_r  <= {fill_r[1:0], 1'b1};
    end
  end

  assign press = sync2_r & ~prev_r & fill_r[2];

endmodule

// File: rtl/timer_controller.sv
// Countdown timer control FSM (IDLE / RUNNING / PAUSED / EXPIRED).
// Optional feature macro: TIMER_ALARM_TIMEOUT_EN -- when defined, EXPIRED
// returns to IDLE by itself after ALARM_SECONDS tick_1hz pulses.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : timer_controller_if.slave (tick, buttons, preset, all_zero in;
//           count_load, count_enable, alarm, display_blank, state out)
module timer_controller
  import timer_pkg::*;
#(
  parameter int ALARM_SECONDS = 10,
  parameter int MIN_W         = 2
) (
  input  logic               clk,
  input  logic               reset,
  timer_controller_if.slave  bus
);

  state_e state_r;
  logic   count_load_r;
  logic   alarm_r;
  logic   blank_r;
  logic   ss_press_s;
  logic   clr_press_s;
  logic   minutes_set_s;

`ifdef TIMER_ALARM_TIMEOUT_EN
  localparam int CNT_W = $clog2(ALARM_SECONDS + 1);
  logic [CNT_W-1:0] tick_cnt_r;
`endif

  button_edge u_ss_edge (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.start_stop),
    .press (ss_press_s)
  );

  button_edge u_clr_edge (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.clear),
    .press (clr_press_s)
  );

  assign minutes_set_s = (bus.start_minutes != MIN_W'(0));

  // Controller FSM; outputs are computed from the next state so they are
  // registered yet line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      count_load_r <= 1'b0;
      alarm_r      <= 1'b0;
      blank_r      <= 1'b0;
`ifdef TIMER_ALARM_TIMEOUT_EN
      tick_cnt_r   <= '0;
`endif
    end else begin
      // Defaults: leaving EXPIRED (or never being there) clears alarm state.
      count_load_r <= 1'b0;
      alarm_r      <= 1'b0;
      blank_r      <= 1'b0;
`ifdef TIMER_ALARM_TIMEOUT_EN
      tick_cnt_r   <= '0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (ss_press_s && minutes_set_s) begin
            state_r <= ST_RUNNING;
          end else begin
            state_r      <= ST_IDLE;
            count_load_r <= 1'b1;
          end
        end
        ST_RUNNING: begin
          if (clr_press_s) begin
            state_r      <= ST_IDLE;
            count_load_r <= 1'b1;
          end else if (bus.all_zero) begin
            state_r <= ST_EXPIRED;
            alarm_r <= 1'b1;
          end else if (ss_press_s) begin
            state_r <= ST_PAUSED;
          end else begin
            state_r <= ST_RUNNING;
          end
        end
        ST_PAUSED: begin
          if (clr_press_s) begin
            state_r      <= ST_IDLE;
            count_load_r <= 1'b1;
          end else if (ss_press_s) begin
            state_r <= ST_RUNNING;
          end else begin
            state_r <= ST_PAUSED;
          end
        end
        ST_EXPIRED: begin
          if (clr_press_s || ss_press_s) begin
            state_r      <= ST_IDLE;
            count_load_r <= 1'b1;
          end else begin
`ifdef TIMER_ALARM_TIMEOUT_EN
            // Auto-return on the tick that completes ALARM_SECONDS.
            if (bus.tick_1hz && (tick_cnt_r == CNT_W'(ALARM_SECONDS - 1))) begin
              state_r      <= ST_IDLE;
              count_load_r <= 1'b1;
            end else begin
              state_r    <= ST_EXPIRED;
              alarm_r    <= 1'b1;
              blank_r    <= bus.tick_1hz ? ~blank_r : blank_r;
              tick_cnt_r <= bus.tick_1hz ? (tick_cnt_r + CNT_W'(1)) : tick_cnt_r;
            end
`else
            state_r <= ST_EXPIRED;
            alarm_r <= 1'b1;
            blank_r <= bus.tick_1hz ? ~blank_r : blank_r;
`endif
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          count_load_r <= 1'b1;
        end
      endcase
    end
  end

  // Decrement strobe must follow tick_1hz with no latency.
  assign bus.count_enable  = (state_r == ST_RUNNING) & bus.tick_1hz & ~bus.all_zero;
  assign bus.count_load    = count_load_r;
  assign bus.alarm         = alarm_r;
  assign bus.display_blank = blank_r;
  assign bus.state         = state_r;

endmodule

// File: tb/tb_timer_controller.sv
// Self-checking bench for timer_controller: a vector table driven through a
// scoreboard queue, plus hand-written sequences for all_zero timing,
// reset during alarm with a held button, and alarm timeout behaviour.
module tb_timer_controller;

  logic clk;
  logic reset;

  timer_controller_if #(.MIN_W(2)) bus ();

  timer_controller #(.ALARM_SECONDS(3), .MIN_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ss;
    logic       clr;
    logic       tick;
    logic       az;
    logic [1:0] mins;
    logic [1:0] st;
    logic       ld;
    logic       en;
    logic       al;
    logic       bl;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input logic rst, ss, clr, tick, az, input logic [1:0] mins,
                      input logic [1:0] st, input logic ld, en, al, bl);
    vec_t v;
    v.rst = rst; v.ss = ss; v.clr = clr; v.tick = tick; v.az = az; v.mins = mins;
    v.st = st; v.ld = ld; v.en = en; v.al = al; v.bl = bl;
    tbl.push_back(v);
  endtask

  // Drive one vector, queue its expectation, compare after the next edge.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    reset = v.rst; bus.start_stop = v.ss; bus.clear = v.clr;
    bus.tick_1hz = v.tick; bus.all_zero = v.az; bus.start_minutes = v.mins;
    sb_q.push_back(v);
    step();
    e = sb_q.pop_front();
    check($sformatf("row%0d_state", idx), int'(bus.state), int'(e.st));
    check($sformatf("row%0d_load", idx), int'(bus.count_load), int'(e.ld));
    check($sformatf("row%0d_enable", idx), int'(bus.count_enable), int'(e.en));
    check($sformatf("row%0d_alarm", idx), int'(bus.alarm), int'(e.al));
    check($sformatf("row%0d_blank", idx), int'(bus.display_blank), int'(e.bl));
  endtask

  // From IDLE with nonzero minutes: start, check same-cycle enable behaviour,
  // then hit all_zero and land in EXPIRED.
  task automatic enter_expired(input string tag);
    bus.start_stop = 1'b1; step(); step();
    bus.start_stop = 1'b0; step();
    check({tag, "_running"}, int'(bus.state), 1);
    bus.tick_1hz = 1'b1; bus.all_zero = 1'b0; #1;
    check({tag, "_en_tick"}, int'(bus.count_enable), 1);
    bus.all_zero = 1'b1; #1;
    check({tag, "_en_allzero"}, int'(bus.count_enable), 0);
    step();
    bus.tick_1hz = 1'b0;
    check({tag, "_exp_state"}, int'(bus.state), 3);
    check({tag, "_exp_alarm"}, int'(bus.alarm), 1);
    check({tag, "_exp_blank"}, int'(bus.display_blank), 0);
  endtask

  initial begin
    reset = 1'b1; bus.start_stop = 1'b0; bus.clear = 1'b0;
    bus.tick_1hz = 1'b0; bus.all_zero = 1'b0; bus.start_minutes = 2'd2;

    //   rst ss clr tk az mins   st ld en al bl
    addv(1, 0, 0, 0, 0, 2'd2, 2'd0, 0, 0, 0, 0);
    addv(1, 0, 0, 0, 0, 2'd2, 2'd0, 0, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 2'd2, 2'd0, 1, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 2'd2, 2'd0, 1, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 2'd2, 2'd0, 1, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 2'd2, 2'd1, 0, 0, 0, 0);
    addv(0, 0, 0, 1, 0, 2'd2, 2'd1, 0, 1, 0, 0);
    addv(0, 0, 0, 0, 0, 2'd2, 2'd1, 0, 0, 0, 0);
    addv(0, 0, 0, 1, 0, 2'd2, 2'd1, 0, 1, 0, 0);
    addv(0, 0, 0, 1, 1, 2'd2, 2'd3, 0, 0, 1, 0);
    addv(0, 0, 0, 0, 1, 2'd2, 2'd3, 0, 0, 1, 0);
    addv(0, 0, 0, 1, 1, 2'd2, 2'd3, 0, 0, 1, 1);
    addv(0, 0, 0, 0, 1, 2'd2, 2'd3, 0, 0, 1, 1);
    addv(0, 0, 0, 1, 1, 2'd2, 2'd3, 0, 0, 1, 0);
    addv(0, 1, 0, 0, 1, 2'd2, 2'd3, 0, 0, 1, 0);
    addv(0, 1, 0, 0, 1, 2'd2, 2'd3, 0, 0, 1, 0);
    addv(0, 0, 0, 0, 0, 2'd2, 2'd0, 1, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 2'd0, 2'd0, 1, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 2'd0, 2'd0, 1, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 2'd2, 2'd0, 1, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 2'd2, 2'd0, 1, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 2'd2, 2'd1, 0, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 2'd2, 2'd1, 0, 0, 0, 0);
    addv(0, 1, 0, 1, 0, 2'd2, 2'd1, 0, 1, 0, 0);
    addv(0, 0, 0, 0, 0, 2'd2, 2'd2, 0, 0, 0, 0);
    addv(0, 0, 0, 1, 0, 2'd2, 2'd2, 0, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 2'd2, 2'd2, 0, 0, 0, 0);
    addv(0, 1, 0, 1, 0, 2'd2, 2'd2, 0, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 2'd2, 2'd1, 0, 0, 0, 0);
    addv(0, 1, 1, 0, 0, 2'd2, 2'd1, 0, 0, 0, 0);
    addv(0, 1, 1, 0, 0, 2'd2, 2'd1, 0, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 2'd2, 2'd0, 1, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Reset while alarming with start_stop held: everything drops, and the
    // held button must not register as a press once reset is released.
    enter_expired("seqA");
    bus.start_stop = 1'b1; reset = 1'b1; step();
    check("rst_exp_state", int'(bus.state), 0);
    check("rst_exp_load", int'(bus.count_load), 0);
    check("rst_exp_enable", int'(bus.count_enable), 0);
    check("rst_exp_alarm", int'(bus.alarm), 0);
    check("rst_exp_blank", int'(bus.display_blank), 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("held_state%0d", i), int'(bus.state), 0);
    end
    check("held_load", int'(bus.count_load), 1);
    bus.start_stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("released_state%0d", i), int'(bus.state), 0);
    end

    // Alarm duration with and without the timeout feature.
    enter_expired("seqB");
`ifdef TIMER_ALARM_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      bus.tick_1hz = 1'b1; step();
      bus.tick_1hz = 1'b0;
      if (i < 2) check($sformatf("timeout_hold%0d", i), int'(bus.state), 3);
      step();
    end
    check("timeout_state", int'(bus.state), 0);
    check("timeout_alarm", int'(bus.alarm), 0);
    check("timeout_blank", int'(bus.display_blank), 0);
    check("timeout_load", int'(bus.count_load), 1);
`else
    for (int i = 0; i < 20; i++) begin
      bus.tick_1hz = 1'b1; step();
      bus.tick_1hz = 1'b0; step();
    end
    check("persist_state", int'(bus.state), 3);
    check("persist_alarm", int'(bus.alarm), 1);
    check("persist_blank", int'(bus.display_blank), 0);
    bus.clear = 1'b1; step(); step();
    bus.clear = 1'b0; step();
    check("clear_exp_state", int'(bus.state), 0);
    check("clear_exp_alarm", int'(bus.alarm), 0);
`endif
    bus.all_zero = 1'b0;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/timer_controller.md
TIMER_CONTROLLER -- requirements
Module: timer_controller

Interface
REQ-001 Parameter ALARM_SECONDS, default 10, number of tick_1hz pulses spent in EXPIRED before auto-return (used only with TIMER_ALARM_TIMEOUT_EN).
REQ-002 Parameter MIN_W, default 2, width of start_minutes.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick_1hz  input  1  one-clk-wide pulse, once per second, from the clock divider.
REQ-006 start_stop  input  1  raw asynchronous button level.
REQ-007 clear  input  1  raw asynchronous button level.
REQ-008 start_minutes  input  MIN_W  switch value preset into the minutes downcounter.
REQ-009 all_zero  input  1  high when minutes, tens and ones counts are all 0.
REQ-010 count_load  output  1  presets counters: minutes=start_minutes, tens=0, ones=0.
REQ-011 count_enable  output  1  decrement strobe to the ones-seconds downcounter.
REQ-012 alarm  output  1  timer expired indicator.
REQ-013 display_blank  output  1  blanks the triple seven-segment display when high.
REQ-014 state  output  2  current FSM state, for debug LEDs.

Function
REQ-015 Each button: 2-flop synchronizer plus rising-edge detect -> one-clk press pulse; held level yields exactly one pulse.
REQ-016 FSM states: IDLE=0, RUNNING=1, PAUSED=2, EXPIRED=3; registered; transitions take effect on the edge after the press pulse (3 clk from raw rise).
REQ-017 IDLE: count_load=1 every cycle; count_enable=0; alarm=0; display_blank=0.
REQ-018 IDLE + start_stop press: -> RUNNING if start_minutes!=0; stays IDLE if start_minutes==0.
REQ-019 RUNNING: count_enable = tick_1hz & ~all_zero, combinational from registered state, zero latency.
REQ-020 RUNNING + all_zero -> EXPIRED; start_stop press -> PAUSED; clear press -> IDLE.
REQ-021 PAUSED: count_enable=0, count_load=0; start_stop press -> RUNNING; clear press -> IDLE.
REQ-022 EXPIRED: alarm=1 (registered, high from first EXPIRED cycle); display_blank toggles on each tick_1hz, starting at 0; start_stop or clear press -> IDLE.
REQ-023 Priority on simultaneous events: clear > all_zero > start_stop.
REQ-024 A tick_1hz coincident with the IDLE->RUNNING or PAUSED->RUNNING press is not counted (state not yet RUNNING).
REQ-025 Any exit from EXPIRED forces alarm=0, display_blank=0 and clears the alarm tick counter.
REQ-026 count_load, alarm and display_blank are registered; count_enable is the only combinational output.

Reset
REQ-027 reset high at a clk edge: state=IDLE, count_load=0, count_enable=0, alarm=0, display_blank=0, synchronizers and edge detectors=0, alarm tick counter=0.
REQ-028 count_load rises on the first edge after reset deasserts; reset mid-run or mid-alarm aborts immediately, same values.
REQ-029 A button held through reset deassertion produces no press pulse.

Configuration
REQ-030 Macro TIMER_ALARM_TIMEOUT_EN defined: EXPIRED counts tick_1hz pulses and returns to IDLE on the edge after the ALARM_SECONDS-th tick; counter width $clog2(ALARM_SECONDS+1).
REQ-031 Macro undefined: no tick counter; EXPIRED persists until a button press or reset.

Structure
REQ-032 Package timer_pkg holds the state typedef/encoding and the state width constant.
REQ-033 One sub-module, button_edge (synchronizer + rising-edge detect), instantiated for start_stop and clear.

Verification
REQ-034 Reset, start_minutes=2, press start_stop -> RUNNING 3 clk later; count_enable pulses exactly with tick_1hz.
REQ-035 RUNNING, assert all_zero -> count_enable=0 same cycle; state=3, alarm=1 next edge; display_blank toggles each tick.
REQ-036 start_minutes=0, press start_stop -> remains IDLE, count_load=1 throughout.
REQ-037 RUNNING, press start_stop -> PAUSED, ticks ignored; press again -> RUNNING; clear and start_stop same cycle -> IDLE.
REQ-038 TIMER_ALARM_TIMEOUT_EN, ALARM_SECONDS=3: EXPIRED, 3 ticks -> IDLE, alarm=0; undefined: alarm stays 1 after 20 ticks.
REQ-039 Assert reset while EXPIRED, start_stop held high -> all outputs 0, state=0; no press pulse after release.
